// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle main controller and its datapath.
interface multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_en;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                illegal_op;
  logic                instr_done;
  logic [CNT_W-1:0]    instr_count;
  logic [3:0]          state_dbg;

  // Controller side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_en, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done, instr_count, state_dbg
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_en, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done, instr_count, state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing each instruction
// over 3-5 cycles, with memory wait states, retired-instruction counter and
// selectable illegal-opcode handling.
module multicycle_control #(
  parameter int OPCODE_W        = 6,
  parameter int CNT_W           = 16,
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12,
    S_RSV13    = 4'd13,
    S_RSV14    = 4'd14,
    S_RSV15    = 4'd15
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;

  logic w_ready;
  logic w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_j, w_illegal;
  logic w_retire;

  logic       w_pc_write, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_branch_cond;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

  assign w_ready   = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign w_is_r    = (bus.opcode == OP_RTYPE);
  assign w_is_lw   = (bus.opcode == OP_LW);
  assign w_is_sw   = (bus.opcode == OP_SW);
  assign w_is_beq  = (bus.opcode == OP_BEQ);
  assign w_is_addi = (bus.opcode == OP_ADDI);
  assign w_is_j    = (bus.opcode == OP_J);
  assign w_illegal = ~(w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_addi | w_is_j);

  // State register with synchronous reset taking priority over every transition
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_lw || w_is_sw) w_next = S_MEM_ADDR;
        else if (w_is_r)        w_next = S_EXEC_R;
        else if (w_is_beq)      w_next = S_BRANCH;
        else if (w_is_addi)     w_next = S_ADDI_EX;
        else if (w_is_j)        w_next = S_JUMP;
        else                    w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      end
      S_MEM_ADDR: w_next = w_is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = w_ready ? S_LW_WB : S_MEM_RD;
      S_LW_WB:    w_next = S_FETCH;
      S_MEM_WR:   w_next = w_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_ADDI_WB:  w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Moore control outputs; only the FETCH loads of IR/PC wait on mem_ready
  always_comb begin
    w_pc_write    = 1'b0;
    w_i_or_d      = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_dst     = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_branch_cond = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_op      = 2'b00;
    w_pc_source   = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = w_ready;
        w_pc_write  = w_ready;
      end
      S_DECODE:   w_alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      S_LW_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_op      = 2'b01;
        w_pc_source   = 2'b01;
        w_branch_cond = 1'b1;
      end
      S_ADDI_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ADDI_WB:  w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  // Retirement: the cycle in which the FSM commits back to FETCH; masked by
  // reset so an aborted instruction never reports completion
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_LW_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP: w_retire = 1'b1;
      S_MEM_WR: w_retire = w_ready;
      S_DECODE: w_retire = w_illegal & ~TRAP_ON_ILLEGAL;
      default:  w_retire = 1'b0;
    endcase
    w_retire = w_retire & rst_n;
  end

  // Retired-instruction counter (wraps) and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_retire) r_count <= r_count + CNT_W'(1);
      if (r_state == S_DECODE && w_illegal) r_illegal <= 1'b1;
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.pc_en       = w_pc_write | (w_branch_cond & bus.zero);
  assign bus.i_or_d      = w_i_or_d;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.ir_write    = w_ir_write;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.reg_write   = w_reg_write;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_op      = w_alu_op;
  assign bus.pc_source   = w_pc_source;
  assign bus.illegal_op  = r_illegal;
  assign bus.instr_done  = w_retire;
  assign bus.instr_count = r_count;
  assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: table-driven per-cycle vectors on a
// default-parameter instance, plus a hand-written sequence on an instance
// with illegal opcodes retired as NOPs, a 4-bit counter and no handshake.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(6), .CNT_W(16)) bus_a ();
  multicycle_control_if #(.OPCODE_W(6), .CNT_W(4))  bus_b ();

  multicycle_control #(
    .OPCODE_W(6), .CNT_W(16), .MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)
  ) dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a.master));

  multicycle_control #(
    .OPCODE_W(6), .CNT_W(4), .MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b.master));

  typedef struct {
    bit          rst_n;
    logic [5:0]  op;
    bit          zero;
    bit          rdy;
    bit          chk;
    logic [3:0]  st;
    bit          done;
    int unsigned cnt;
    bit          ill;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  // Control word {pc_write,pc_en,i_or_d,mem_read,mem_write,ir_write,
  // mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_source}
  function automatic logic [15:0] exp_ctrl(logic [3:0] st, bit rdy, bit z);
    logic pw, pe, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pw, pe, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; pe = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pe = z; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; pe = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pe, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  function automatic void v(bit r, logic [5:0] op, bit z, bit rdy, bit chk,
                            logic [3:0] st, bit done, int unsigned cnt, bit ill);
    vec_t e;
    e.rst_n = r; e.op = op; e.zero = z; e.rdy = rdy; e.chk = chk;
    e.st = st; e.done = done; e.cnt = cnt; e.ill = ill;
    vq.push_back(e);
  endfunction

  task automatic cmp(string name, longint unsigned act, longint unsigned req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  logic [15:0] w_ctrl_a;
  assign w_ctrl_a = {bus_a.pc_write, bus_a.pc_en, bus_a.i_or_d, bus_a.mem_read,
                     bus_a.mem_write, bus_a.ir_write, bus_a.mem_to_reg,
                     bus_a.reg_dst, bus_a.reg_write, bus_a.alu_src_a,
                     bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_source};

  initial begin
    logic [3:0] j_seq [3];
    int unsigned cntb;
    j_seq[0] = 4'd0; j_seq[1] = 4'd1; j_seq[2] = 4'd11;

    // ---- vector table for instance A ----
    v(0, OP_R, 0, 1, 0, 0, 0, 0, 0);
    v(0, OP_R, 0, 1, 1, 0, 0, 0, 0);
    // R-type 0-1-6-7
    v(1, OP_R, 0, 1, 1, 0, 0, 0, 0);
    v(1, OP_R, 0, 1, 1, 1, 0, 0, 0);
    v(1, OP_R, 0, 1, 1, 6, 0, 0, 0);
    v(1, OP_R, 0, 1, 1, 7, 1, 0, 0);
    // lw 0-1-2-3-4
    v(1, OP_LW, 0, 1, 1, 0, 0, 1, 0);
    v(1, OP_LW, 0, 1, 1, 1, 0, 1, 0);
    v(1, OP_LW, 0, 1, 1, 2, 0, 1, 0);
    v(1, OP_LW, 0, 1, 1, 3, 0, 1, 0);
    v(1, OP_LW, 0, 1, 1, 4, 1, 1, 0);
    // sw 0-1-2-5
    v(1, OP_SW, 0, 1, 1, 0, 0, 2, 0);
    v(1, OP_SW, 0, 1, 1, 1, 0, 2, 0);
    v(1, OP_SW, 0, 1, 1, 2, 0, 2, 0);
    v(1, OP_SW, 0, 1, 1, 5, 1, 2, 0);
    // beq 0-1-8
    v(1, OP_BEQ, 0, 1, 1, 0, 0, 3, 0);
    v(1, OP_BEQ, 0, 1, 1, 1, 0, 3, 0);
    v(1, OP_BEQ, 0, 1, 1, 8, 1, 3, 0);
    // addi 0-1-9-10
    v(1, OP_ADDI, 0, 1, 1, 0, 0, 4, 0);
    v(1, OP_ADDI, 0, 1, 1, 1, 0, 4, 0);
    v(1, OP_ADDI, 0, 1, 1, 9, 0, 4, 0);
    v(1, OP_ADDI, 0, 1, 1, 10, 1, 4, 0);
    // j 0-1-11; 23 cycles in total for the six instructions
    v(1, OP_J, 0, 1, 1, 0, 0, 5, 0);
    v(1, OP_J, 0, 1, 1, 1, 0, 5, 0);
    v(1, OP_J, 0, 1, 1, 11, 1, 5, 0);
    // beq taken (zero=1) then not taken
    v(1, OP_BEQ, 1, 1, 1, 0, 0, 6, 0);
    v(1, OP_BEQ, 1, 1, 1, 1, 0, 6, 0);
    v(1, OP_BEQ, 1, 1, 1, 8, 1, 6, 0);
    v(1, OP_BEQ, 0, 1, 1, 0, 0, 7, 0);
    v(1, OP_BEQ, 0, 1, 1, 1, 0, 7, 0);
    v(1, OP_BEQ, 0, 1, 1, 8, 1, 7, 0);
    // lw with 3 FETCH waits and 2 MEM_RD waits: 10 cycles
    v(1, OP_LW, 0, 0, 1, 0, 0, 8, 0);
    v(1, OP_LW, 0, 0, 1, 0, 0, 8, 0);
    v(1, OP_LW, 0, 0, 1, 0, 0, 8, 0);
    v(1, OP_LW, 0, 1, 1, 0, 0, 8, 0);
    v(1, OP_LW, 0, 1, 1, 1, 0, 8, 0);
    v(1, OP_LW, 0, 1, 1, 2, 0, 8, 0);
    v(1, OP_LW, 0, 0, 1, 3, 0, 8, 0);
    v(1, OP_LW, 0, 0, 1, 3, 0, 8, 0);
    v(1, OP_LW, 0, 1, 1, 3, 0, 8, 0);
    v(1, OP_LW, 0, 1, 1, 4, 1, 8, 0);
    // sw with mem_ready low in DECODE (ignored) and one MEM_WR wait
    v(1, OP_SW, 0, 1, 1, 0, 0, 9, 0);
    v(1, OP_SW, 0, 0, 1, 1, 0, 9, 0);
    v(1, OP_SW, 0, 1, 1, 2, 0, 9, 0);
    v(1, OP_SW, 0, 0, 1, 5, 0, 9, 0);
    v(1, OP_SW, 0, 1, 1, 5, 1, 9, 0);
    // illegal opcode traps and stays
    v(1, OP_BAD, 0, 1, 1, 0, 0, 10, 0);
    v(1, OP_BAD, 0, 1, 1, 1, 0, 10, 0);
    v(1, OP_BAD, 0, 1, 1, 12, 0, 10, 1);
    v(1, OP_BAD, 0, 0, 1, 12, 0, 10, 1);
    v(1, OP_BAD, 0, 1, 1, 12, 0, 10, 1);
    // reset out of TRAP
    v(0, OP_BAD, 0, 1, 1, 12, 0, 10, 1);
    v(1, OP_J, 0, 1, 1, 0, 0, 0, 0);
    v(1, OP_J, 0, 1, 1, 1, 0, 0, 0);
    v(1, OP_J, 0, 1, 1, 11, 1, 0, 0);
    // reset during MEM_RD aborts the lw
    v(1, OP_LW, 0, 1, 1, 0, 0, 1, 0);
    v(1, OP_LW, 0, 1, 1, 1, 0, 1, 0);
    v(1, OP_LW, 0, 1, 1, 2, 0, 1, 0);
    v(1, OP_LW, 0, 0, 1, 3, 0, 1, 0);
    v(0, OP_LW, 0, 0, 1, 3, 0, 1, 0);
    // reset during LW_WB suppresses the retirement pulse
    v(1, OP_LW, 0, 1, 1, 0, 0, 0, 0);
    v(1, OP_LW, 0, 1, 1, 1, 0, 0, 0);
    v(1, OP_LW, 0, 1, 1, 2, 0, 0, 0);
    v(1, OP_LW, 0, 1, 1, 3, 0, 0, 0);
    v(0, OP_LW, 0, 1, 1, 4, 0, 0, 0);
    v(1, OP_R, 0, 1, 1, 0, 0, 0, 0);

    bus_b.opcode = OP_J; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      rst_a           = vq[i].rst_n;
      bus_a.opcode    = vq[i].op;
      bus_a.zero      = vq[i].zero;
      bus_a.mem_ready = vq[i].rdy;
      #1;
      if (vq[i].chk) begin
        cmp($sformatf("a_state[%0d]", i), bus_a.state_dbg, vq[i].st);
        cmp($sformatf("a_ctrl[%0d]", i), w_ctrl_a,
            exp_ctrl(vq[i].st, vq[i].rdy, vq[i].zero));
        cmp($sformatf("a_done[%0d]", i), bus_a.instr_done, vq[i].done);
        cmp($sformatf("a_count[%0d]", i), bus_a.instr_count, vq[i].cnt);
        cmp($sformatf("a_illegal[%0d]", i), bus_a.illegal_op, vq[i].ill);
      end
    end

    // ---- instance B: NOP on illegal, 4-bit counter, mem_ready ignored ----
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1; bus_b.opcode = OP_BAD; #1;
    cmp("b_reset_state", bus_b.state_dbg, 0);
    cmp("b_fetch_irw_no_handshake", bus_b.ir_write, 1);
    cmp("b_reset_count", bus_b.instr_count, 0);
    @(negedge clk); #1;
    cmp("b_decode_state", bus_b.state_dbg, 1);
    cmp("b_illegal_done", bus_b.instr_done, 1);
    cmp("b_illegal_flag_pre", bus_b.illegal_op, 0);
    @(negedge clk); bus_b.opcode = OP_J; #1;
    cmp("b_back_to_fetch", bus_b.state_dbg, 0);
    cmp("b_count_after_illegal", bus_b.instr_count, 1);
    cmp("b_illegal_flag", bus_b.illegal_op, 1);
    cntb = 1;
    for (int k = 0; k < 16; k++) begin
      for (int ph = 0; ph < 3; ph++) begin
        if (!(k == 0 && ph == 0)) begin
          @(negedge clk); #1;
        end
        cmp($sformatf("b_state[%0d.%0d]", k, ph), bus_b.state_dbg, j_seq[ph]);
        cmp($sformatf("b_done[%0d.%0d]", k, ph), bus_b.instr_done, ph == 2);
        cmp($sformatf("b_count[%0d.%0d]", k, ph), bus_b.instr_count, cntb);
      end
      cntb = (cntb + 1) % 16;
    end
    @(negedge clk); #1;
    cmp("b_count_wrap_17", bus_b.instr_count, 1);
    cmp("b_illegal_sticky", bus_b.illegal_op, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
